// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising PRBS-7 (x^7 + x^6 + 1) receive checker
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        received PRBS bit
//   din_valid  din is consumed only when high
//   locked     checker is synchronised to the incoming sequence
//   err_pulse  one-cycle pulse, the cycle after each errored beat while locked
//   err_count  saturating count of errors seen while locked
//   sync_state current state: 0 SEED, 1 VERIFY, 2 LOCKED
module prbs7_checker #(
  parameter int SYNC_LEN    = 8,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       sync_state
);

  localparam int MW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_LEN - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [EW-1:0] LOSS_LIM  = EW'(LOSS_THRESH);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t          state;
  logic [7:1]      s;
  logic [2:0]      seed_cnt;
  logic [MW-1:0]   match_cnt;
  logic [WW-1:0]   win_cnt;
  logic [EW-1:0]   win_err;

  logic            pred;
  logic            mism;
  logic [7:1]      s_din;
  logic [EW-1:0]   win_err_nx;

  // s[7] is the bit seven beats ago, s[6] six beats ago.
  assign pred       = s[7] ^ s[6];
  assign mism       = din ^ pred;
  assign s_din      = {s[6:1], din};
  assign win_err_nx = win_err + EW'(mism);
  assign sync_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      s         <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        SEED: begin
          if (din_valid) begin
            s <= s_din;
            if (seed_cnt == 3'd6) begin
              seed_cnt <= '0;
              // An all-zero register would predict zeros forever; reseed instead.
              if (s_din != '0) begin
                state     <= VERIFY;
                match_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + 3'd1;
            end
          end
        end

        VERIFY: begin
          if (din_valid) begin
            s <= s_din;
            if (!mism) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == SYNC_LAST) begin
                state   <= LOCK;
                locked  <= 1'b1;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              match_cnt <= '0;
              seed_cnt  <= '0;
              state     <= SEED;
            end
          end
        end

        LOCK: begin
          if (din_valid) begin
            // Free-run on the prediction so a corrupted bit is not fed back
            // into the register and reported again six and seven beats later.
            s <= {s[6:1], pred};
            if (mism) begin
              err_pulse <= 1'b1;
              if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
            end
            if (win_err_nx >= LOSS_LIM) begin
              state     <= SEED;
              locked    <= 1'b0;
              seed_cnt  <= '0;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err_nx;
            end
          end
        end

        default: begin
          state  <= SEED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - self-checking bench for prbs7_checker
module tb_prbs7_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;

  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic [1:0]  st_a;
  logic        locked_b, pulse_b;
  logic [3:0]  cnt_b;
  logic [1:0]  st_b;

  initial forever #5 clk = ~clk;

  prbs7_checker #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a), .sync_state(st_a)
  );

  prbs7_checker #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b), .sync_state(st_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history queue of the last seven bits the checker holds
  // (oldest first), plain integer counters.
  int m_state, m_seed, m_match, m_wcnt, m_werr, m_cnt_a, m_cnt_b;
  bit m_locked, m_pulse;
  bit m_hist[$];

  // Transmit-side generator: b[n] = b[n-7] ^ b[n-6], oldest first.
  bit g_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_seed = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
    m_cnt_a = 0; m_cnt_b = 0; m_locked = 0; m_pulse = 0;
    m_hist = {};
    for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit d, input bit v);
    bit p;
    int ones;
    m_pulse = 0;
    if (v) begin
      p = m_hist[0] ^ m_hist[1];
      case (m_state)
        0: begin
          m_hist.push_back(d); void'(m_hist.pop_front());
          m_seed++;
          if (m_seed == 7) begin
            m_seed = 0;
            ones = 0;
            foreach (m_hist[i]) ones += int'(m_hist[i]);
            if (ones != 0) begin m_state = 1; m_match = 0; end
          end
        end
        1: begin
          m_hist.push_back(d); void'(m_hist.pop_front());
          if (d == p) begin
            m_match++;
            if (m_match == 8) begin m_state = 2; m_locked = 1; m_wcnt = 0; m_werr = 0; end
          end else begin
            m_match = 0; m_seed = 0; m_state = 0;
          end
        end
        default: begin
          m_hist.push_back(p); void'(m_hist.pop_front());
          if (d != p) begin
            m_pulse = 1;
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 15) m_cnt_b++;
            m_werr++;
          end
          if (m_werr >= 4) begin
            m_state = 0; m_locked = 0; m_seed = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
          end else if (m_wcnt == 63) begin
            m_wcnt = 0; m_werr = 0;
          end else begin
            m_wcnt++;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    check("locked_a", locked_a, m_locked);
    check("pulse_a", pulse_a, m_pulse);
    check("count_a", cnt_a, m_cnt_a);
    check("state_a", st_a, m_state);
    check("locked_b", locked_b, m_locked);
    check("pulse_b", pulse_b, m_pulse);
    check("count_b", cnt_b, m_cnt_b);
    check("state_b", st_b, m_state);
  endtask

  task automatic tick(input bit d, input bit v, input bit r);
    din = d; din_valid = v; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else model_step(d, v);
    #1;
    check_all();
  endtask

  task automatic gen_seed(input bit [6:0] sd);
    g_hist = {};
    for (int i = 6; i >= 0; i--) g_hist.push_back(sd[i]);
  endtask

  function automatic bit gen_next();
    bit b;
    b = g_hist[0] ^ g_hist[1];
    g_hist.push_back(b);
    void'(g_hist.pop_front());
    return b;
  endfunction

  task automatic beat(input bit flip);
    bit g;
    g = gen_next();
    tick(g ^ flip, 1'b1, 1'b0);
  endtask

  task automatic idle();
    tick(1'($urandom), 1'b0, 1'b0);
  endtask

  function automatic bit [6:0] rand_seed();
    return 7'($urandom_range(1, 127));
  endfunction

  int lock_at, pulses, pulse_at, vb;

  initial begin
    model_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_state", st_a, 2'd0);
    check("rst_locked", locked_a, 1'b0);
    check("rst_count", cnt_a, 16'd0);

    // 1: clean stream from 7'h7F locks one cycle after beat 15
    gen_seed(7'h7F);
    lock_at = -1;
    for (int i = 1; i <= 200; i++) begin
      beat(1'b0);
      if (lock_at < 0 && locked_a === 1'b1) lock_at = i;
    end
    check("t1_lock_beat", lock_at, 15);
    check("t1_state", st_a, 2'd2);
    check("t1_count", cnt_a, 16'd0);

    // 2: single inverted bit gives exactly one pulse, right after beat 40
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 60; i++) begin
      beat(i == 40);
      if (pulse_a === 1'b1) begin pulses++; pulse_at = i; end
    end
    check("t2_pulses", pulses, 1);
    check("t2_pulse_beat", pulse_at, 40);
    check("t2_count", cnt_a, 16'd1);
    check("t2_locked", locked_a, 1'b1);

    // 3: four errors in one window drop lock; clean stream relocks in 15
    tick(1'b0, 1'b0, 1'b1);
    gen_seed(rand_seed());
    for (int i = 1; i <= 15; i++) beat(1'b0);
    check("t3_locked", locked_a, 1'b1);
    for (int j = 1; j <= 7; j++) beat(j[0]);
    check("t3_loss_locked", locked_a, 1'b0);
    check("t3_loss_state", st_a, 2'd0);
    check("t3_loss_count", cnt_a, 16'd4);
    lock_at = -1;
    for (int i = 1; i <= 40 && lock_at < 0; i++) begin
      beat(1'b0);
      if (locked_a === 1'b1) lock_at = i;
    end
    check("t3_relock_beat", lock_at, 15);
    check("t3_count_kept", cnt_a, 16'd4);

    // 4: all-zero seed is rejected
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) tick(1'b0, 1'b1, 1'b0);
    check("t4_zero_state", st_a, 2'd0);
    gen_seed(rand_seed());
    lock_at = -1;
    for (int i = 1; i <= 40 && lock_at < 0; i++) begin
      beat(1'b0);
      if (locked_a === 1'b1) lock_at = i;
    end
    check("t4_lock_beat", lock_at, 15);

    // 5: valid toggling, errors at valid beats 10 and 70
    tick(1'b0, 1'b0, 1'b1);
    gen_seed(rand_seed());
    for (int i = 1; i <= 15; i++) beat(1'b0);
    pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      beat(i == 10 || i == 70);
      if (pulse_a === 1'b1) pulses++;
      idle();
    end
    check("t5_pulses", pulses, 2);
    check("t5_count", cnt_a, 16'd2);
    check("t5_locked", locked_a, 1'b1);

    // 6: saturation of the 4-bit counter, then reset mid-stream
    tick(1'b0, 1'b0, 1'b1);
    gen_seed(rand_seed());
    for (int i = 1; i <= 15; i++) beat(1'b0);
    for (int k = 0; k < 20; k++)
      for (int i = 1; i <= 70; i++) beat(i == 70);
    check("t6_sat_b", cnt_b, 4'd15);
    check("t6_count_a", cnt_a, 16'd20);
    check("t6_locked", locked_b, 1'b1);
    for (int i = 1; i <= 5; i++) beat(1'b0);
    tick(~gen_next(), 1'b1, 1'b1);
    check("t6_rst_count_b", cnt_b, 4'd0);
    check("t6_rst_pulse_b", pulse_b, 1'b0);
    check("t6_rst_locked_b", locked_b, 1'b0);
    check("t6_rst_state_b", st_b, 2'd0);

    // Random traffic: gaps, sparse and bursty errors, occasional garbage
    gen_seed(rand_seed());
    for (int i = 0; i < 3000; i++) begin
      vb = int'($urandom_range(0, 99));
      if (vb < 25) idle();
      else if (vb < 28) beat(1'b1);
      else if (vb < 29) tick(1'($urandom), 1'b1, 1'b0);
      else beat(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
